id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register. Sits directly downstream of reg_file.
//  Takes reg_file rs1/rs2 plus the decoded fields and resolves operand hazards:
//  bypasses from EX, MEM and WB, and a one-bubble stall on load-use.
//  Registers resolved operands into the EX stage with a 1-cycle latency.
// PARAMETERS
//  DWIDTH  32  datapath width
//  CTRL_W  16  width of opaque ALU/memory control bundle (cpu_pkg::CTRL_W)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  id_valid       in   1       ID slot holds a real instruction
//  id_pc          in   32      PC of ID instruction
//  id_rs1_id/rs2  in   5 each  source register IDs (same IDs driven to reg_file)
//  id_rs1_used/2  in   1 each  source actually read by instruction
//  id_rd_id       in   5       destination ID
//  id_rd_we       in   1       instruction writes rd
//  id_is_load     in   1       instruction is a load
//  id_imm         in   DWIDTH  decoded immediate
//  id_ctrl        in   CTRL_W  control bundle
//  rf_rs1/rf_rs2  in   DWIDTH  reg_file read data
//  ex_alu_result  in   DWIDTH  combinational ALU output of instruction now in EX
//  mem_rd_id/we   in   5/1     EX/MEM register destination
//  mem_result     in   DWIDTH  final value of MEM instruction (ALU or load data)
//  wb_rd_id/we    in   5/1     WB destination (same as reg_file write port)
//  wb_result      in   DWIDTH  WB data
//  ex_stall       in   1       downstream stall: hold EX register
//  flush          in   1       branch redirect: kill ID->EX transfer
//  id_stall       out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_ctrl,
//  ex_rd_id, ex_rd_we, ex_is_load   out  registered EX-stage fields
//  hazard_cnt     out  32      count of load-use bubbles inserted
// BEHAVIOUR
//  Reset: all ex_* outputs and hazard_cnt = 0; id_stall = 0 while rst.
//  Operand select per source s (never forwarded when s_id == 0):
//   EX  if ex_valid & ex_rd_we & !ex_is_load & ex_rd_id==s -> ex_alu_result
//   MEM if mem_rd_we & mem_rd_id==s                         -> mem_result
//   WB  if wb_rd_we & wb_rd_id==s                           -> wb_result
//   else rf value. Priority EX > MEM > WB > RF (youngest wins).
//  load_use = id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd_id!=0 &
//   ((id_rs1_used & id_rs1_id==ex_rd_id) | (id_rs2_used & id_rs2_id==ex_rd_id)).
//  id_stall = !flush & (ex_stall | load_use).
//  Register update per posedge, priority order:
//   rst      -> all zero
//   flush    -> ex_valid=0, ex_rd_we=0, ex_is_load=0 (other fields don't care)
//   ex_stall -> hold all ex_* unchanged
//   load_use -> bubble: ex_valid=0, ex_rd_we=0, ex_is_load=0; hazard_cnt+1
//   else     -> capture ID fields, ex_valid=id_valid, ops = selected values
//  Capture of !id_valid forces ex_rd_we=0 and ex_is_load=0.
//  Operand select re-evaluates every cycle; nothing latched while ID is held.
//  A WB write during a stall is therefore seen through reg_file next cycle.
//  hazard_cnt saturates at 32'hFFFF_FFFF; unchanged on flush or ex_stall.
//  Load-use resolves in exactly one bubble: the load moves to MEM and its data
//  arrives through mem_result on the retry.
// STRUCTURE
//  cpu_pkg: CTRL_W, fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
//  Sub-module fwd_mux, instantiated once per operand: compares IDs, emits
//  fwd_sel_e and the selected DWIDTH data.
//  Top level holds hazard detect, pipeline register and counter.
// TESTING
//  Reset: hold rst 2 cycles -> all ex_*=0, hazard_cnt=0, id_stall=0.
//  EX bypass: EX add x5 with alu=0x1234; ID rs1=x5, rf_rs1=0 -> next ex_op1=0x1234.
//  Priority: EX/MEM/WB all write x7 = 1/2/3 -> ex_op2=1; drop EX we -> 2;
//   drop MEM -> 3.
//  Load-use: EX lw x3; ID rs2=x3 -> id_stall=1 one cycle, bubble, hazard_cnt=1;
//   next cycle mem_result=0xBEEF -> ex_op2=0xBEEF, ex_valid=1.
//  x0: all stages write x0 = 0xFFFF; ID rs1=x0, rf_rs1=0 -> ex_op1=0; no stall
//   even if EX is lw x0.
//  Flush vs load_use in the same cycle -> ex_valid=0, id_stall=0, hazard_cnt
//   unchanged; ex_stall for 3 cycles -> ex_* frozen, id_stall=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control width and forwarding-source encoding
package cpu_pkg;
  localparam int CTRL_W = 16;
  typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks youngest matching producer (EX > MEM > WB > RF) for one source operand, never for x0
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [4:0]    src_i,
  input  logic          ex_we_i,
  input  logic [4:0]    ex_rd_i,
  input  logic [DW-1:0] ex_data_i,
  input  logic          mem_we_i,
  input  logic [4:0]    mem_rd_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_we_i,
  input  logic [4:0]    wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [DW-1:0] rf_data_i,
  output fwd_sel_e      sel_o,
  output logic [DW-1:0] data_o
);
  always_comb begin
    sel_o = (src_i == 5'd0)                   ? FWD_RF  :
            (ex_we_i  && ex_rd_i  == src_i)   ? FWD_EX  :
            (mem_we_i && mem_rd_i == src_i)   ? FWD_MEM :
            (wb_we_i  && wb_rd_i  == src_i)   ? FWD_WB  : FWD_RF;
    data_o = sel_o == FWD_EX  ? ex_data_i  :
             sel_o == FWD_MEM ? mem_data_i :
             sel_o == FWD_WB  ? wb_data_i  : rf_data_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand bypassing, load-use bubble and bubble counter
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_i,
  input  logic [4:0]        id_rs1_id_i,
  input  logic [4:0]        id_rs2_id_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [4:0]        id_rd_id_i,
  input  logic              id_rd_we_i,
  input  logic              id_is_load_i,
  input  logic [DWIDTH-1:0] id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DWIDTH-1:0] rf_rs1_i,
  input  logic [DWIDTH-1:0] rf_rs2_i,
  input  logic [DWIDTH-1:0] ex_alu_result_i,
  input  logic [4:0]        mem_rd_id_i,
  input  logic              mem_rd_we_i,
  input  logic [DWIDTH-1:0] mem_result_i,
  input  logic [4:0]        wb_rd_id_i,
  input  logic              wb_rd_we_i,
  input  logic [DWIDTH-1:0] wb_result_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_o,
  output logic [DWIDTH-1:0] ex_op1_o,
  output logic [DWIDTH-1:0] ex_op2_o,
  output logic [DWIDTH-1:0] ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [4:0]        ex_rd_id_o,
  output logic              ex_rd_we_o,
  output logic              ex_is_load_o,
  output logic [31:0]       hazard_cnt_o
);
  logic              valid_q, valid_d, rd_we_q, rd_we_d, is_load_q, is_load_d;
  logic [31:0]       pc_q, pc_d, cnt_q, cnt_d;
  logic [DWIDTH-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d, op1_fwd, op2_fwd;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        rd_id_q, rd_id_d;
  logic              ex_fwd_ok, load_use, take, bubble;
  fwd_sel_e          op1_sel_unused, op2_sel_unused;
  assign ex_fwd_ok = valid_q & rd_we_q & ~is_load_q;
  fwd_mux #(.DW(DWIDTH)) u_fwd1 (
    .src_i(id_rs1_id_i), .ex_we_i(ex_fwd_ok), .ex_rd_i(rd_id_q), .ex_data_i(ex_alu_result_i),
    .mem_we_i(mem_rd_we_i), .mem_rd_i(mem_rd_id_i), .mem_data_i(mem_result_i),
    .wb_we_i(wb_rd_we_i), .wb_rd_i(wb_rd_id_i), .wb_data_i(wb_result_i),
    .rf_data_i(rf_rs1_i), .sel_o(op1_sel_unused), .data_o(op1_fwd)
  );
  fwd_mux #(.DW(DWIDTH)) u_fwd2 (
    .src_i(id_rs2_id_i), .ex_we_i(ex_fwd_ok), .ex_rd_i(rd_id_q), .ex_data_i(ex_alu_result_i),
    .mem_we_i(mem_rd_we_i), .mem_rd_i(mem_rd_id_i), .mem_data_i(mem_result_i),
    .wb_we_i(wb_rd_we_i), .wb_rd_i(wb_rd_id_i), .wb_data_i(wb_result_i),
    .rf_data_i(rf_rs2_i), .sel_o(op2_sel_unused), .data_o(op2_fwd)
  );
  always_comb begin
    load_use = id_valid_i & valid_q & is_load_q & rd_we_q & (rd_id_q != 5'd0) &
               ((id_rs1_used_i & id_rs1_id_i == rd_id_q) | (id_rs2_used_i & id_rs2_id_i == rd_id_q));
    id_stall_o = ~rst & ~flush_i & (ex_stall_i | load_use);
    take = ~flush_i & ~ex_stall_i & ~load_use;
    bubble = flush_i | (~ex_stall_i & load_use);
    valid_d = bubble ? 1'b0 : take ? id_valid_i : valid_q;
    rd_we_d = bubble ? 1'b0 : take ? id_valid_i & id_rd_we_i : rd_we_q;
    is_load_d = bubble ? 1'b0 : take ? id_valid_i & id_is_load_i : is_load_q;
    pc_d = take ? id_pc_i : pc_q;
    op1_d = take ? op1_fwd : op1_q;
    op2_d = take ? op2_fwd : op2_q;
    imm_d = take ? id_imm_i : imm_q;
    ctrl_d = take ? id_ctrl_i : ctrl_q;
    rd_id_d = take ? id_rd_id_i : rd_id_q;
    cnt_d = (~flush_i & ~ex_stall_i & load_use & ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_we_q <= 1'b0;
      is_load_q <= 1'b0;
      pc_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      imm_q <= '0;
      ctrl_q <= '0;
      rd_id_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_we_q <= rd_we_d;
      is_load_q <= is_load_d;
      pc_q <= pc_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      imm_q <= imm_d;
      ctrl_q <= ctrl_d;
      rd_id_q <= rd_id_d;
      cnt_q <= cnt_d;
    end
  end
  assign ex_valid_o = valid_q;
  assign ex_pc_o = pc_q;
  assign ex_op1_o = op1_q;
  assign ex_op2_o = op2_q;
  assign ex_imm_o = imm_q;
  assign ex_ctrl_o = ctrl_q;
  assign ex_rd_id_o = rd_id_q;
  assign ex_rd_we_o = rd_we_q;
  assign ex_is_load_o = is_load_q;
  assign hazard_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of bypass priority, load-use bubble, x0, flush and stall
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 1'b0, rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic mem_rd_we, wb_rd_we, ex_stall, flush;
  logic [31:0] id_pc, id_imm, rf_rs1, rf_rs2, ex_alu_result, mem_result, wb_result;
  logic [4:0] id_rs1_id, id_rs2_id, id_rd_id, mem_rd_id, wb_rd_id;
  logic [CTRL_W-1:0] id_ctrl;
  logic id_stall, ex_valid, ex_rd_we, ex_is_load;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm, hazard_cnt;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0] ex_rd_id;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_id_i(id_rs1_id), .id_rs2_id_i(id_rs2_id), .id_rs1_used_i(id_rs1_used),
    .id_rs2_used_i(id_rs2_used), .id_rd_id_i(id_rd_id), .id_rd_we_i(id_rd_we),
    .id_is_load_i(id_is_load), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2), .ex_alu_result_i(ex_alu_result),
    .mem_rd_id_i(mem_rd_id), .mem_rd_we_i(mem_rd_we), .mem_result_i(mem_result),
    .wb_rd_id_i(wb_rd_id), .wb_rd_we_i(wb_rd_we), .wb_result_i(wb_result),
    .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(id_stall),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2),
    .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .ex_rd_id_o(ex_rd_id), .ex_rd_we_o(ex_rd_we),
    .ex_is_load_o(ex_is_load), .hazard_cnt_o(hazard_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [31:0] pc, input logic [4:0] rd, input logic we, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_rd_id = rd; id_rd_we = we; id_is_load = ld;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rs1_id = 5'd0; id_rs2_id = 5'd0;
  endtask
  initial begin
    rst = 1'b1; ex_stall = 1'b1; flush = 1'b0;
    instr(32'h0, 5'd0, 1'b0, 1'b0);
    id_imm = '0; id_ctrl = '0; rf_rs1 = '0; rf_rs2 = '0; ex_alu_result = '0;
    mem_rd_id = '0; mem_rd_we = 1'b0; mem_result = '0;
    wb_rd_id = '0; wb_rd_we = 1'b0; wb_result = '0;
    step(); step();
    chk("rst_id_stall", {31'b0, id_stall}, 32'd0);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ex_op1", ex_op1, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_hazard_cnt", hazard_cnt, 32'd0);
    rst = 1'b0; ex_stall = 1'b0;
    instr(32'h100, 5'd5, 1'b1, 1'b0);
    step();
    instr(32'h104, 5'd6, 1'b1, 1'b0);
    id_rs1_id = 5'd5; id_rs1_used = 1'b1; rf_rs1 = 32'h0; ex_alu_result = 32'h1234;
    #1 chk("exbyp_no_stall", {31'b0, id_stall}, 32'd0);
    step();
    chk("exbyp_op1", ex_op1, 32'h1234);
    chk("exbyp_pc", ex_pc, 32'h104);
    chk("exbyp_valid", {31'b0, ex_valid}, 32'd1);
    instr(32'h108, 5'd7, 1'b1, 1'b0);
    step();
    instr(32'h10C, 5'd10, 1'b0, 1'b0);
    id_rs2_id = 5'd7; id_rs2_used = 1'b1; rf_rs2 = 32'h55;
    ex_alu_result = 32'd1; mem_rd_id = 5'd7; mem_rd_we = 1'b1; mem_result = 32'd2;
    wb_rd_id = 5'd7; wb_rd_we = 1'b1; wb_result = 32'd3;
    step();
    chk("prio_ex", ex_op2, 32'd1);
    step();
    chk("prio_mem", ex_op2, 32'd2);
    mem_rd_we = 1'b0;
    step();
    chk("prio_wb", ex_op2, 32'd3);
    wb_rd_we = 1'b0;
    step();
    chk("prio_rf", ex_op2, 32'h55);
    instr(32'h200, 5'd3, 1'b1, 1'b1);
    step();
    chk("lw_in_ex", {31'b0, ex_is_load}, 32'd1);
    instr(32'h204, 5'd8, 1'b1, 1'b0);
    id_rs2_id = 5'd3; id_rs2_used = 1'b1;
    #1 chk("lu_stall", {31'b0, id_stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_we", {31'b0, ex_rd_we}, 32'd0);
    chk("lu_hazard_cnt", hazard_cnt, 32'd1);
    chk("lu_stall_released", {31'b0, id_stall}, 32'd0);
    mem_rd_id = 5'd3; mem_rd_we = 1'b1; mem_result = 32'hBEEF;
    step();
    chk("lu_retry_op2", ex_op2, 32'hBEEF);
    chk("lu_retry_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_retry_rd", {27'b0, ex_rd_id}, 32'd8);
    mem_rd_we = 1'b0;
    instr(32'h300, 5'd0, 1'b1, 1'b1);
    step();
    instr(32'h304, 5'd11, 1'b0, 1'b0);
    id_rs1_used = 1'b1; id_rs2_used = 1'b1; rf_rs1 = 32'h0; rf_rs2 = 32'h0;
    ex_alu_result = 32'hFFFF; mem_rd_id = 5'd0; mem_rd_we = 1'b1; mem_result = 32'hFFFF;
    wb_rd_id = 5'd0; wb_rd_we = 1'b1; wb_result = 32'hFFFF;
    #1 chk("x0_no_stall", {31'b0, id_stall}, 32'd0);
    step();
    chk("x0_op1", ex_op1, 32'd0);
    chk("x0_op2", ex_op2, 32'd0);
    chk("x0_valid", {31'b0, ex_valid}, 32'd1);
    chk("x0_hazard_cnt", hazard_cnt, 32'd1);
    mem_rd_we = 1'b0; wb_rd_we = 1'b0;
    instr(32'h400, 5'd4, 1'b1, 1'b1);
    step();
    instr(32'h404, 5'd12, 1'b1, 1'b0);
    id_rs1_id = 5'd4; id_rs1_used = 1'b1; flush = 1'b1;
    #1 chk("flush_no_stall", {31'b0, id_stall}, 32'd0);
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_is_load", {31'b0, ex_is_load}, 32'd0);
    chk("flush_hazard_cnt", hazard_cnt, 32'd1);
    flush = 1'b0;
    instr(32'h500, 5'd9, 1'b1, 1'b0);
    id_imm = 32'hABCD; id_ctrl = 16'h5A5A;
    step();
    chk("pre_stall_pc", ex_pc, 32'h500);
    instr(32'h600, 5'd13, 1'b1, 1'b0);
    id_imm = 32'h1111; id_ctrl = 16'h0F0F; ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_id_stall", {31'b0, id_stall}, 32'd1);
      step();
      chk("stall_pc", ex_pc, 32'h500);
      chk("stall_imm", ex_imm, 32'hABCD);
      chk("stall_ctrl", {16'b0, ex_ctrl}, 32'h5A5A);
      chk("stall_rd", {27'b0, ex_rd_id}, 32'd9);
      chk("stall_valid", {31'b0, ex_valid}, 32'd1);
    end
    ex_stall = 1'b0;
    instr(32'h700, 5'd14, 1'b1, 1'b1);
    id_valid = 1'b0;
    step();
    chk("inv_valid", {31'b0, ex_valid}, 32'd0);
    chk("inv_rd_we", {31'b0, ex_rd_we}, 32'd0);
    chk("inv_is_load", {31'b0, ex_is_load}, 32'd0);
    chk("final_hazard_cnt", hazard_cnt, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
